// File: rtl/spi_mem_pkg.sv
// Shared opcode constants and FSM state type for the SPI-to-RAM command sequencer.
package spi_mem_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {ARB, RD_WAIT, RD_CAPT} state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // r_last is 1 when requester 0 held the most recent grant.
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
    end else if (advance) begin
      r_last <= gnt[0];
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Decodes SPI command words into RAM accesses and shares the single RAM port
// with a host requester through a round-robin arbiter.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              spi_overrun
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  state_t            r_state;
  logic              r_rx_valid_d;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_spi_pend;
  logic              r_spi_rd;
  logic [DATA_W-1:0] r_spi_wdata;
  logic              r_owner_spi;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_host_gnt;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_host_rvalid;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_spi_overrun;

  logic       w_capture;
  logic       w_drop;
  logic       w_in_arb;
  logic [1:0] w_req;
  logic [1:0] w_gnt;

  assign w_capture = rx_valid & ~r_rx_valid_d;
  assign w_in_arb  = (r_state == ARB);
  assign w_drop    = w_capture & (r_spi_pend | (~w_in_arb & r_owner_spi));
  // The host keeps host_req high during its grant cycle, so mask it then.
  assign w_req     = {host_req & ~r_host_gnt & w_in_arb, r_spi_pend & w_in_arb};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .advance(|w_gnt),
    .gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ARB;
      r_rx_valid_d  <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_spi_pend    <= 1'b0;
      r_spi_rd      <= 1'b0;
      r_spi_wdata   <= '0;
      r_owner_spi   <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_spi_overrun <= 1'b0;
    end else begin
      r_rx_valid_d  <= rx_valid;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_host_rvalid <= 1'b0;

      // A non-dropped capture never coincides with an SPI grant (pend would be set).
      if (w_capture) begin
        r_tx_valid <= 1'b0;
        if (w_drop) begin
          r_spi_overrun <= 1'b1;
        end else begin
          case (rx_data[9:8])
            CMD_WR_ADDR: r_wr_ptr <= rx_data[ADDR_W-1:0];
            CMD_RD_ADDR: r_rd_ptr <= rx_data[ADDR_W-1:0];
            CMD_WR_DATA: begin
              r_spi_pend  <= 1'b1;
              r_spi_rd    <= 1'b0;
              r_spi_wdata <= rx_data[DATA_W-1:0];
            end
            default: begin
              r_spi_pend <= 1'b1;
              r_spi_rd   <= 1'b1;
            end
          endcase
        end
      end

      case (r_state)
        ARB: begin
          if (w_gnt[0]) begin
            r_spi_pend  <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= ~r_spi_rd;
            r_mem_wdata <= r_spi_wdata;
            if (r_spi_rd) begin
              r_mem_addr  <= r_rd_ptr;
              r_rd_ptr    <= r_rd_ptr + PTR_ONE;
              r_owner_spi <= 1'b1;
              r_state     <= RD_WAIT;
            end else begin
              r_mem_addr <= r_wr_ptr;
              r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            end
          end else if (w_gnt[1]) begin
            r_host_gnt  <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= host_we;
            r_mem_addr  <= host_addr;
            r_mem_wdata <= host_wdata;
            if (!host_we) begin
              r_owner_spi <= 1'b0;
              r_state     <= RD_WAIT;
            end
          end
        end
        RD_WAIT: r_state <= RD_CAPT;
        RD_CAPT: begin
          r_state <= ARB;
          if (r_owner_spi) begin
            r_tx_data  <= mem_rdata;
            r_tx_valid <= 1'b1;
          end else begin
            r_host_rdata  <= mem_rdata;
            r_host_rvalid <= 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign host_gnt    = r_host_gnt;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign spi_overrun = r_spi_overrun;

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Sequences the SPI slave's 10-bit command words into accesses on one single-port synchronous RAM, and shares that RAM port with a local host requester. It decodes `rx_data[9:8]`, holds the write and read address pointers, and arbitrates the memory port round-robin. It returns read data to the SPI slave on `tx_data`/`tx_valid`. It sits between the SPI slave and the RAM in the SPI wrapper.

## Interface
- `ADDR_W`, 8: memory address width; pointers wrap modulo 2^ADDR_W.
- `DATA_W`, 8: memory data width; must equal `rx_data` payload width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 10: SPI command word; [9:8] opcode, [7:0] payload.
- `rx_valid` in 1: level from the SPI slave; a command is taken only on its 0->1 transition.
- `tx_data` out DATA_W: read data for the SPI slave.
- `tx_valid` out 1: `tx_data` is valid; held high until the next command capture.
- `host_req` in 1: host access request; host holds it and all `host_*` inputs stable until `host_gnt`.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_gnt` out 1: one-cycle pulse, coincident with the granted `mem_en` cycle.
- `host_rdata` out DATA_W: host read data.
- `host_rvalid` out 1: one-cycle pulse qualifying `host_rdata`.
- `mem_en`, `mem_we` out 1: RAM port enables; registered.
- `mem_addr` out ADDR_W: RAM address; registered.
- `mem_wdata` out DATA_W: RAM write data; registered.
- `mem_rdata` in DATA_W: RAM read data, valid on the edge after `mem_en` is sampled (1-cycle latency).
- `spi_overrun` out 1: sticky flag, set when an SPI command is dropped; cleared only by reset.

## Operation
- **Capture.** A command is captured when `rx_valid`=1 and `rx_valid_d`=0. `rx_valid_d` is a registered copy of `rx_valid`, reset to 0.
- **Opcode 00.** `wr_ptr` <= payload. No memory access.
- **Opcode 10.** `rd_ptr` <= payload. No memory access.
- **Opcode 01.** Sets `spi_pend`: write payload to `wr_ptr`. After the grant, `wr_ptr` <= `wr_ptr`+1 (wraps).
- **Opcode 11.** Sets `spi_pend`: read `rd_ptr`. After the grant, `rd_ptr` <= `rd_ptr`+1 (wraps).
- **tx_valid clear.** Every capture clears `tx_valid`, including a dropped capture.
- **Overrun.** A capture while `spi_pend`=1, or while an SPI read is in RD_WAIT/RD_CAPT, is dropped whatever its opcode. Pointers are unchanged and `spi_overrun` <= 1.
- **FSM states:**
  - ARB: both requesters are candidates.
  - RD_WAIT: the RAM samples the read.
  - RD_CAPT: read data is registered to its owner.
- **ARB grant rule.**
  - If only one of `spi_pend`/`host_req` is set, grant it.
  - If both are set, grant the one not granted last (`last_spi` bit, reset 0, so SPI wins the first tie).
  - A grant drives `mem_*` registers for exactly one cycle and updates `last_spi`.
- **Write grant.** Stays in ARB; a back-to-back grant is allowed next cycle.
- **Read grant.** ARB -> RD_WAIT -> RD_CAPT -> ARB. No grant is issued in RD_WAIT or RD_CAPT. Leaving RD_CAPT loads `tx_data`/`tx_valid`=1 (SPI owner) or `host_rdata`/`host_rvalid`=1 (host owner).
- **Pend clear.** `spi_pend` clears on its grant edge.
- **Reset values.** All outputs 0. State ARB; pointers, pend, `last_spi` and `rx_valid_d` all 0. A reset mid-read discards the access; the host must re-request.

## Timing
- E0 samples the `rx_valid` rise: capture, `spi_pend`<=1.
- E1: grant; `mem_en` high for the cycle after E1.
- E2: RAM registers data.
- E3: `tx_valid`<=1 and `tx_data`<=`mem_rdata`.
- SPI read latency: 3 edges from capture to `tx_valid`. SPI write: `mem_en`/`mem_we` high after E1.
- A host request present at edge E (no contention, FSM in ARB) gets `host_gnt` after E. For a read, `host_rvalid` follows after E+2.
- A capture and a grant on the same edge are both honoured: the captured command only becomes a candidate on the next edge.
- Worst-case SPI wait behind a host read: 3 edges added.

## Structure
- Package `spi_mem_pkg`:
  - opcode constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - FSM state enum {ARB, RD_WAIT, RD_CAPT}.
- One sub-module, `rr_arb2`: 2-input round-robin arbiter.
  - Inputs: `req[1:0]`, `advance`.
  - Outputs: one-hot `gnt[1:0]`; holds the `last` bit internally.
- Pointer, pend, FSM and output registers live in the top level.

## Test plan
- **SPI write/read back.** rx 0x005 (wr_ptr=5), then 0x1A7, then 0x205, then 0x300. Expect `mem_we`@addr 5 data 0xA7; `tx_data`=0xA7 with `tx_valid` 3 edges after the last capture; `rd_ptr`=6.
- **Wrap.** rx 0x0FF, then 0x111, then 0x122. Expect writes at addr 0xFF then 0x00.
- **Tie.** `spi_pend` and `host_req` rise on the same edge, twice. Expect SPI granted first, host second; on the next tie, alternate.
- **Host read.** `host_req`, `host_we`=0, `host_addr`=0x10, RAM holds 0x3C. Expect `host_gnt` then, 2 edges later, `host_rvalid` with `host_rdata`=0x3C. SPI pend arriving meanwhile is granted in ARB after RD_CAPT.
- **Overrun.** Second `rx_valid` rise (0x155) while an SPI read is in RD_WAIT. Expect `spi_overrun`=1, no write, `wr_ptr` unchanged.
- **Async reset.** Assert `rst_n`=0 in RD_WAIT. Expect all outputs 0 immediately with no clock edge, FSM=ARB, no `tx_valid` after release.
